// File: rtl/param_disp_hc595_if.sv
// rtl/param_disp_hc595_if.sv - settings inputs and 74HC595 pin bundle for param_disp_hc595
//
// Signals:
//   wave_sel[5:0], mode_sel[3:0], F[8:0], T[10:0], Z[6:0]  settings from key_control
//   ds, shcp, stcp, oe_n                                   74HC595 chain pins
// Modports:
//   master : drives the settings, observes the pins (key_control / board side)
//   slave  : consumes the settings, drives the pins (param_disp_hc595)

interface param_disp_hc595_if;
    logic [5:0]  wave_sel;
    logic [3:0]  mode_sel;
    logic [8:0]  F;
    logic [10:0] T;
    logic [6:0]  Z;
    logic        ds;
    logic        shcp;
    logic        stcp;
    logic        oe_n;

    modport master (
        output wave_sel, mode_sel, F, T, Z,
        input  ds, shcp, stcp, oe_n
    );

    modport slave (
        input  wave_sel, mode_sel, F, T, Z,
        output ds, shcp, stcp, oe_n
    );
endinterface

// File: rtl/param_disp_hc595.sv
// rtl/param_disp_hc595.sv - shows the most recently changed setting on a 6-digit 7-seg via 74HC595
//
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      param_disp_hc595_if.slave: wave_sel/mode_sel/F/T/Z in, ds/shcp/stcp/oe_n out
// Parameters:
//   SCAN_CNT clocks per digit refresh, must be >= 15*CLK_DIV+4
//   CLK_DIV  clocks per SHCP period, even, >= 2

module param_disp_hc595 #(
    parameter int SCAN_CNT = 50000,
    parameter int CLK_DIV  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    param_disp_hc595_if.slave    bus
);

    localparam int SCW  = $clog2(SCAN_CNT);
    localparam int DIVW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [SCW-1:0]  SC_LAST  = SCW'(SCAN_CNT - 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
    localparam logic [DIVW-1:0] DIV_HALF = DIVW'(CLK_DIV / 2);
    localparam logic [DIVW-1:0] LAT_LAST = DIVW'(CLK_DIV / 2 - 1);

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] n);
        add3 = (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // ---------------- field tracking ----------------
    logic [5:0]  prev_wave;
    logic [3:0]  prev_mode;
    logic [8:0]  prev_f;
    logic [10:0] prev_t;
    logic [6:0]  prev_z;
    logic        prev_valid;
    logic [2:0]  cur_field;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_wave  <= '0;
            prev_mode  <= '0;
            prev_f     <= '0;
            prev_t     <= '0;
            prev_z     <= '0;
            prev_valid <= 1'b0;
            cur_field  <= 3'd2;
        end else begin
            prev_wave  <= bus.wave_sel;
            prev_mode  <= bus.mode_sel;
            prev_f     <= bus.F;
            prev_t     <= bus.T;
            prev_z     <= bus.Z;
            prev_valid <= 1'b1;
            // Priority order resolves simultaneous edits: F > T > Z > mode > wave
            if (prev_valid) begin
                if (bus.F != prev_f)               cur_field <= 3'd2;
                else if (bus.T != prev_t)          cur_field <= 3'd3;
                else if (bus.Z != prev_z)          cur_field <= 3'd4;
                else if (bus.mode_sel != prev_mode) cur_field <= 3'd1;
                else if (bus.wave_sel != prev_wave) cur_field <= 3'd0;
            end
        end
    end

    // ---------------- double-dabble BCD ----------------
    typedef enum logic {BCD_IDLE, BCD_RUN} bcd_state_t;
    bcd_state_t  bcd_state, bcd_next;
    logic [10:0] sel_val, last_val, bin_sr;
    logic [2:0]  last_field;
    logic [15:0] bcd_work, bcd_adj, bcd_shift, bcd_reg;
    logic [3:0]  iter;
    logic        bcd_start;

    always_comb begin
        sel_val = '0;
        case (cur_field)
            3'd0:    sel_val = {5'd0, bus.wave_sel};
            3'd1:    sel_val = {7'd0, bus.mode_sel};
            3'd2:    sel_val = {2'd0, bus.F};
            3'd3:    sel_val = bus.T;
            3'd4:    sel_val = {4'd0, bus.Z};
            default: sel_val = '0;
        endcase
    end

    assign bcd_start = (cur_field != last_field) || (sel_val != last_val);
    assign bcd_adj   = {add3(bcd_work[15:12]), add3(bcd_work[11:8]),
                        add3(bcd_work[7:4]),   add3(bcd_work[3:0])};
    assign bcd_shift = {bcd_adj[14:0], bin_sr[10]};

    always_ff @(posedge clk) begin
        if (!reset_n) bcd_state <= BCD_IDLE;
        else          bcd_state <= bcd_next;
    end

    always_comb begin
        bcd_next = bcd_state;
        case (bcd_state)
            BCD_IDLE: if (bcd_start)      bcd_next = BCD_RUN;
            BCD_RUN:  if (iter == 4'd10)  bcd_next = BCD_IDLE;
            default:                      bcd_next = BCD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bcd_work   <= '0;
            bin_sr     <= '0;
            iter       <= '0;
            bcd_reg    <= '0;
            last_val   <= '0;
            last_field <= 3'd2;
        end else begin
            case (bcd_state)
                BCD_IDLE: begin
                    if (bcd_start) begin
                        bin_sr     <= sel_val;
                        bcd_work   <= '0;
                        iter       <= '0;
                        last_val   <= sel_val;
                        last_field <= cur_field;
                    end
                end
                BCD_RUN: begin
                    bcd_work <= bcd_shift;
                    bin_sr   <= {bin_sr[9:0], 1'b0};
                    iter     <= iter + 4'd1;
                    // Publish only the finished result so the display never sees partial sums
                    if (iter == 4'd10) bcd_reg <= bcd_shift;
                end
                default: ;
            endcase
        end
    end

    // ---------------- digit content ----------------
    logic [2:0] digit_idx;
    logic [7:0] digit_seg;
    logic [5:0] digit_sel;

    always_comb begin
        digit_seg = 8'hFF;
        case (digit_idx)
            3'd0: digit_seg = seg_code(bcd_reg[3:0]);
            3'd1: digit_seg = (bcd_reg[15:4]  == '0) ? 8'hFF : seg_code(bcd_reg[7:4]);
            3'd2: digit_seg = (bcd_reg[15:8]  == '0) ? 8'hFF : seg_code(bcd_reg[11:8]);
            3'd3: digit_seg = (bcd_reg[15:12] == '0) ? 8'hFF : seg_code(bcd_reg[15:12]);
            3'd5: digit_seg = seg_code({1'b0, cur_field}) & 8'h7F;
            default: digit_seg = 8'hFF;
        endcase
    end

    assign digit_sel = 6'd1 << digit_idx;

    // ---------------- scan / shift FSM ----------------
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH} scan_state_t;
    scan_state_t     scan_state, scan_next;
    logic [SCW-1:0]  scan_cnt;
    logic            tick;
    logic [13:0]     frame;
    logic [3:0]      bit_idx;
    logic [DIVW-1:0] div_cnt;
    logic [DIVW-1:0] lat_cnt;

    assign tick = (scan_cnt == SC_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) scan_state <= S_IDLE;
        else          scan_state <= scan_next;
    end

    always_comb begin
        scan_next = scan_state;
        case (scan_state)
            S_IDLE:  if (tick) scan_next = S_LOAD;
            S_LOAD:  scan_next = S_SHIFT;
            S_SHIFT: if (div_cnt == DIV_LAST && bit_idx == 4'd0) scan_next = S_LATCH;
            S_LATCH: if (lat_cnt == LAT_LAST) scan_next = S_IDLE;
            default: scan_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scan_cnt  <= '0;
            frame     <= '0;
            bit_idx   <= '0;
            div_cnt   <= '0;
            lat_cnt   <= '0;
            digit_idx <= '0;
            bus.ds    <= 1'b0;
            bus.shcp  <= 1'b0;
            bus.stcp  <= 1'b0;
            bus.oe_n  <= 1'b1;
        end else begin
            scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
            case (scan_state)
                S_LOAD: begin
                    frame   <= {digit_seg, digit_sel};
                    bit_idx <= 4'd13;
                    div_cnt <= '0;
                end
                S_SHIFT: begin
                    if (div_cnt == '0) begin
                        bus.ds   <= frame[bit_idx];
                        bus.shcp <= 1'b0;
                    end
                    if (div_cnt == DIV_HALF) bus.shcp <= 1'b1;
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_idx == 4'd0) begin
                            // With CLK_DIV=2 the last rising edge shares this clock, so keep
                            // it high here and let LATCH pull it low one clock later
                            bus.shcp <= (DIV_HALF == DIV_LAST);
                            bus.stcp <= 1'b1;
                            lat_cnt  <= '0;
                        end else begin
                            bit_idx <= bit_idx - 4'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    bus.shcp <= 1'b0;
                    if (lat_cnt == LAT_LAST) begin
                        bus.stcp  <= 1'b0;
                        bus.oe_n  <= 1'b0;
                        digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_param_disp_hc595.sv
// tb/tb_param_disp_hc595.sv - self-checking bench for param_disp_hc595

module tb_param_disp_hc595;

    localparam int SCAN_CNT = 80;
    localparam int CLK_DIV  = 4;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    param_disp_hc595_if bus ();

    param_disp_hc595 #(.SCAN_CNT(SCAN_CNT), .CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [5:0]       wave;
        logic [3:0]       mode;
        logic [8:0]       f;
        logic [10:0]      t;
        logic [6:0]       z;
        logic [5:0][7:0]  seg;   // seg[i] = expected segment byte of digit i
    } vec_t;

    vec_t vecs [11];

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- pin monitor ----------------
    logic        shcp_q = 1'b0, stcp_q = 1'b0, ds_q = 1'b0;
    logic [13:0] shreg = '0;
    logic [13:0] frames [$];
    int          edge_cnt = 0, frame_edges = 0, stcp_len = 0, last_stcp_len = 0, ds_glitch = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            edge_cnt = 0;
            stcp_len = 0;
        end else begin
            if (bus.shcp && !shcp_q) begin
                if (bus.ds !== ds_q) ds_glitch++;
                shreg = {shreg[12:0], bus.ds};
                edge_cnt++;
            end
            if (bus.stcp && !stcp_q) begin
                frames.push_back(shreg);
                frame_edges = edge_cnt;
                edge_cnt    = 0;
            end
            if (bus.stcp) stcp_len++;
            else if (stcp_q) begin
                last_stcp_len = stcp_len;
                stcp_len      = 0;
            end
        end
        shcp_q = bus.shcp;
        stcp_q = bus.stcp;
        ds_q   = bus.ds;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_frames(input int n, input string name);
        int budget;
        budget = n * SCAN_CNT + 200;
        while (frames.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (frames.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout, got %0d frames, required %0d", name, frames.size(), n);
        end
    endtask

    task automatic apply(input int v);
        bus.wave_sel = vecs[v].wave;
        bus.mode_sel = vecs[v].mode;
        bus.F        = vecs[v].f;
        bus.T        = vecs[v].t;
        bus.Z        = vecs[v].z;
    endtask

    task automatic check_digits(input int v);
        logic [5:0] sel;
        int idx;
        for (int i = 0; i < 6 && i < frames.size(); i++) begin
            sel = frames[i][5:0];
            check($sformatf("v%0d_sel_onehot", v), 32'($onehot(sel)), 32'd1);
            idx = 0;
            for (int k = 0; k < 6; k++) if (sel[k]) idx = k;
            check($sformatf("v%0d_digit%0d_seg", v, idx), 32'(frames[i][13:6]), 32'(vecs[v].seg[idx]));
        end
    endtask

    initial begin
        //           wave    mode   F        T          Z       {d5,d4,d3,d2,d1,d0}
        vecs[0]  = '{6'd0,  4'd0,  9'd123, 11'd0,    7'd0,   {8'h24,8'hFF,8'hFF,8'hF9,8'hA4,8'hB0}};
        vecs[1]  = '{6'd0,  4'd0,  9'd123, 11'd2047, 7'd0,   {8'h30,8'hFF,8'hA4,8'hC0,8'h99,8'hF8}};
        vecs[2]  = '{6'd0,  4'd0,  9'd9,   11'd2047, 7'd5,   {8'h24,8'hFF,8'hFF,8'hFF,8'hFF,8'h90}};
        vecs[3]  = '{6'd0,  4'd7,  9'd9,   11'd2047, 7'd5,   {8'h79,8'hFF,8'hFF,8'hFF,8'hFF,8'hF8}};
        vecs[4]  = '{6'd40, 4'd7,  9'd9,   11'd2047, 7'd5,   {8'h40,8'hFF,8'hFF,8'hFF,8'h99,8'hC0}};
        vecs[5]  = '{6'd40, 4'd7,  9'd9,   11'd2047, 7'd100, {8'h19,8'hFF,8'hFF,8'hF9,8'hC0,8'hC0}};
        vecs[6]  = '{6'd41, 4'd7,  9'd0,   11'd5,    7'd100, {8'h24,8'hFF,8'hFF,8'hFF,8'hFF,8'hC0}};
        vecs[7]  = '{6'd41, 4'd7,  9'd0,   11'd1000, 7'd3,   {8'h30,8'hFF,8'hF9,8'hC0,8'hC0,8'hC0}};
        vecs[8]  = '{6'd41, 4'd2,  9'd0,   11'd1000, 7'd99,  {8'h19,8'hFF,8'hFF,8'hFF,8'h90,8'h90}};
        vecs[9]  = '{6'd63, 4'd15, 9'd0,   11'd1000, 7'd99,  {8'h79,8'hFF,8'hFF,8'hFF,8'hF9,8'h92}};
        vecs[10] = '{6'd63, 4'd15, 9'd511, 11'd1000, 7'd99,  {8'h24,8'hFF,8'hFF,8'h92,8'hF9,8'hF9}};

        // Reset with F=123 already present
        reset_n = 1'b0;
        apply(0);
        repeat (3) @(negedge clk);
        check("reset_ds",   32'(bus.ds),   32'd0);
        check("reset_shcp", 32'(bus.shcp), 32'd0);
        check("reset_stcp", 32'(bus.stcp), 32'd0);
        check("reset_oe_n", 32'(bus.oe_n), 32'd1);
        frames.delete();
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("oe_n_before_latch", 32'(bus.oe_n), 32'd1);

        // Digit order and wrap over 7 frames, then the content of the first six
        wait_frames(7, "wrap_frames");
        for (int i = 0; i < 7 && i < frames.size(); i++)
            check($sformatf("wrap_sel%0d", i), 32'(frames[i][5:0]), 32'd1 << (i % 6));
        check_digits(0);
        check("frame_shcp_edges", 32'(frame_edges), 32'd14);
        @(negedge clk);
        check("stcp_width", 32'(last_stcp_len), 32'(CLK_DIV / 2));
        check("ds_stable", 32'(ds_glitch), 32'd0);
        check("oe_n_after_latch", 32'(bus.oe_n), 32'd0);

        // Table of setting changes
        for (int v = 1; v < 11; v++) begin
            apply(v);
            if (v == 1) begin
                repeat (12) @(negedge clk);
                check("bcd_before_done", 32'(dut.bcd_reg), 32'h0123);
                @(negedge clk);
                check("bcd_done", 32'(dut.bcd_reg), 32'h2047);
                repeat (87) @(negedge clk);
            end else begin
                repeat (100) @(negedge clk);
            end
            frames.delete();
            wait_frames(6, $sformatf("v%0d_frames", v));
            check_digits(v);
        end

        // Reset in the middle of a shift
        begin
            int budget;
            budget = 2 * SCAN_CNT;
            while (edge_cnt != 7 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            check("mid_shift_reached", 32'(edge_cnt), 32'd7);
        end
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_shcp", 32'(bus.shcp), 32'd0);
        check("abort_stcp", 32'(bus.stcp), 32'd0);
        check("abort_oe_n", 32'(bus.oe_n), 32'd1);
        frames.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_frames(1, "post_reset_frame");
        check("post_reset_edges", 32'(frame_edges), 32'd14);
        if (frames.size() > 0)
            check("post_reset_sel", 32'(frames[0][5:0]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
